// File: rtl/alu_writeback_stage_if.sv
// Handshake bus for the ALU writeback stage: the ALU-side input beat and
// the register-file-side writeback beat.
interface alu_writeback_stage_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 4;
  localparam int unsigned FLAG_W = 4;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              zf;
  logic              cf;
  logic              of;
  logic              nf;
  logic              flag_we;
  logic [DEST_W-1:0] dest;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic [FLAG_W-1:0] wb_flags;

  modport master (
    output in_valid, result, zf, cf, of, nf, flag_we, dest, out_ready,
    input  in_ready, out_valid, wb_data, wb_dest, wb_flags
  );

  modport slave (
    input  in_valid, result, zf, cf, of, nf, flag_we, dest, out_ready,
    output in_ready, out_valid, wb_data, wb_dest, wb_flags
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry skid buffer, architectural STATUS flags and condition evaluation.
// Optional sticky overflow flag enabled by defining STICKY_OVF_EN.
module alu_writeback_stage (
  input  logic                    clk,
  input  logic                    rst,
  alu_writeback_stage_if.slave    bus,
  input  logic [2:0]              cond,
  output logic                    cond_true,
  input  logic                    clr_sov,
  output logic                    sov,
  output logic [3:0]              status
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 4;
  localparam int unsigned FLAG_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic [FLAG_W-1:0] flags;
  } beat_t;

  beat_t             in_beat;
  beat_t             out_q, out_d;
  beat_t             skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q;
  logic [FLAG_W-1:0] status_q;
  logic              accept;
  logic              drain;

  // Flags are carried as {N,Z,C,O}
  always_comb begin
    in_beat.data  = bus.result;
    in_beat.dest  = bus.dest;
    in_beat.flags = {bus.nf, bus.zf, bus.cf, bus.of};
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  // Occupancy update; a skid entry excludes a same-cycle accept because in_ready is low
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      status_q     <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      if (accept && bus.flag_we) begin
        status_q <= in_beat.flags;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wb_data   = out_q.data;
  assign bus.wb_dest   = out_q.dest;
  assign bus.wb_flags  = out_q.flags;
  assign status        = status_q;

  // Condition codes evaluated on architectural STATUS {N,Z,C,O}
  always_comb begin
    cond_true = 1'b1;
    case (cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = status_q[2];
      3'd2:    cond_true = ~status_q[2];
      3'd3:    cond_true = status_q[1];
      3'd4:    cond_true = ~status_q[1];
      3'd5:    cond_true = status_q[3];
      3'd6:    cond_true = status_q[0];
      default: cond_true = status_q[3] ^ status_q[0];
    endcase
  end

`ifdef STICKY_OVF_EN
  logic sov_q;

  // Set has priority over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sov_q <= 1'b0;
    end else if (accept && bus.flag_we && bus.of) begin
      sov_q <= 1'b1;
    end else if (clr_sov) begin
      sov_q <= 1'b0;
    end
  end

  assign sov = sov_q;
`else
  logic unused_clr_sov;
  assign unused_clr_sov = clr_sov;
  assign sov            = 1'b0;
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios then random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_alu_writeback_stage;
`ifdef STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] cond;
  logic       cond_true;
  logic       clr_sov;
  logic       sov;
  logic [3:0] status;

  alu_writeback_stage_if bus ();

  alu_writeback_stage dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cond      (cond),
    .cond_true (cond_true),
    .clr_sov   (clr_sov),
    .sov       (sov),
    .status    (status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: beats in flight in acceptance order {data,dest,flags}
  logic [39:0] exp_q[$];
  bit          exp_in_ready = 1'b1;
  logic [3:0]  exp_status   = 4'h0;
  bit          exp_sov      = 1'b0;
  bit          fresh        = 1'b0;
  bit          live         = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ref(input logic [2:0] c, input logic [3:0] st);
    bit n, z, cy, o;
    {n, z, cy, o} = st;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return o;
      default: return n != o;
    endcase
  endfunction

  // Model: acceptance and STATUS/SOV bookkeeping at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_in_ready = 1'b1;
      exp_status   = 4'h0;
      exp_sov      = 1'b0;
      fresh        = 1'b1;
      live         = 1'b1;
    end else if (live) begin
      bit         acc;
      logic [3:0] f;
      f   = {bus.nf, bus.zf, bus.cf, bus.of};
      acc = bus.in_valid && exp_in_ready;
      if (acc) begin
        exp_q.push_back({bus.result, bus.dest, f});
        fresh = 1'b0;
        if (bus.flag_we) exp_status = f;
      end
      if (STICKY) begin
        if (acc && bus.flag_we && f[0]) exp_sov = 1'b1;
        else if (clr_sov)               exp_sov = 1'b0;
      end
      exp_in_ready = exp_q.size() < 2;
    end
  end

  // Monitor: compare presented outputs, retire a beat on each output handshake
  always @(negedge clk) begin
    if (live) begin
      check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("wb_data", bus.wb_data, exp_q[0][39:8]);
        check("wb_dest", 32'(bus.wb_dest), 32'(exp_q[0][7:4]));
        check("wb_flags", 32'(bus.wb_flags), 32'(exp_q[0][3:0]));
      end else if (fresh) begin
        check("wb_zero", {bus.wb_data[23:0], bus.wb_dest, bus.wb_flags}, 32'h0);
      end
      check("status", 32'(status), 32'(exp_status));
      check("cond_true", 32'(cond_true), 32'(cond_ref(cond, exp_status)));
      check("sov", 32'(sov), 32'(exp_sov));
      if (!rst && bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [3:0] ds,
                       input logic [3:0] f, input bit we, input bit ordy);
    bus.in_valid  = v;
    bus.result    = d;
    bus.dest      = ds;
    {bus.nf, bus.zf, bus.cf, bus.of} = f;
    bus.flag_we   = we;
    bus.out_ready = ordy;
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    cond    = 3'd0;
    clr_sov = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_status", 32'(status), 0);
    check("rst_sov", 32'(sov), 0);

    // Single beat
    drive(1, 32'h5, 4'd3, 4'b0000, 1, 1);
    step();
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_data", bus.wb_data, 32'h5);
    check("single_dest", 32'(bus.wb_dest), 3);
    check("single_status", 32'(status), 0);
    drive(0, 0, 0, 0, 0, 1);
    step();

    // Backpressure fills skid
    drive(1, 32'hA, 4'd1, 4'b0000, 0, 0);
    step();
    drive(1, 32'hB, 4'd2, 4'b0000, 0, 0);
    step();
    check("bp_in_ready_low", 32'(bus.in_ready), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("bp_hold_data", bus.wb_data, 32'hA);
    check("bp_hold_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    step();
    check("bp_second_data", bus.wb_data, 32'hB);
    check("bp_second_valid", 32'(bus.out_valid), 1);
    check("bp_ready_back", 32'(bus.in_ready), 1);
    step();
    check("bp_empty", 32'(bus.out_valid), 0);

    // Flags and conditions
    drive(1, 32'h7, 4'd4, 4'b0100, 1, 1);
    step();
    bus.in_valid = 1'b0;
    check("flag_status", 32'(status), 32'h4);
    cond = 3'd1;
    #1 check("cond_z", 32'(cond_true), 1);
    cond = 3'd2;
    #1 check("cond_nz", 32'(cond_true), 0);
    drive(1, 32'h8, 4'd5, 4'b0000, 0, 1);
    step();
    bus.in_valid = 1'b0;
    check("flag_we0_status", 32'(status), 32'h4);

    // Signed less-than
    drive(1, 32'h9, 4'd6, 4'b1000, 1, 1);
    step();
    cond = 3'd7;
    #1 check("cond_lt_true", 32'(cond_true), 1);
    drive(1, 32'h10, 4'd7, 4'b1001, 1, 1);
    step();
    bus.in_valid = 1'b0;
    check("cond_lt_false", 32'(cond_true), 0);

    // Sticky overflow
    drive(1, 32'h11, 4'd8, 4'b0001, 1, 1);
    step();
    check("sov_set", 32'(sov), 32'(STICKY));
    drive(1, 32'h12, 4'd9, 4'b0000, 1, 1);
    step();
    check("sov_keep", 32'(sov), 32'(STICKY));
    drive(0, 0, 0, 0, 0, 1);
    clr_sov = 1'b1;
    step();
    clr_sov = 1'b0;
    check("sov_clear", 32'(sov), 0);
    drive(1, 32'h13, 4'd10, 4'b0001, 1, 1);
    clr_sov = 1'b1;
    step();
    clr_sov = 1'b0;
    bus.in_valid = 1'b0;
    check("sov_set_wins", 32'(sov), 32'(STICKY));
    clr_sov = 1'b1;
    step();
    clr_sov = 1'b0;

    // Reset with both entries full
    drive(1, 32'h14, 4'd1, 4'b1111, 1, 0);
    step();
    drive(1, 32'h15, 4'd2, 4'b1111, 1, 0);
    step();
    check("mid_full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    drive(1, 32'h16, 4'd3, 4'b1111, 1, 1);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_ready", 32'(bus.in_ready), 1);
    check("mid_rst_status", 32'(status), 0);
    check("mid_rst_sov", 32'(sov), 0);
    repeat (3) step();
    check("mid_no_stale", 32'(bus.out_valid), 0);

    // Random traffic with occasional resets
    repeat (3000) begin
      drive($urandom_range(0, 9) < 7, $urandom, 4'($urandom), 4'($urandom),
            1'($urandom), $urandom_range(0, 9) < 6);
      cond    = 3'($urandom);
      clr_sov = $urandom_range(0, 19) == 0;
      rst     = $urandom_range(0, 99) == 0;
      step();
    end
    rst     = 1'b0;
    clr_sov = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) step();
    check("final_drained", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 SHALL have ports: Clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: IN_VALID  in  1  ALU output beat valid.
REQ-004 SHALL have: IN_READY  out  1  stage can accept a beat; registered.
REQ-005 SHALL have: Result  in  32  ALU result.
REQ-006 SHALL have: ZF, CF, OF, NF  in  1 each  ALU flags for this beat.
REQ-007 SHALL have: FLAG_WE  in  1  beat updates architectural STATUS.
REQ-008 SHALL have: DEST  in  4  destination register index.
REQ-009 SHALL have: OUT_VALID  out  1  writeback beat valid.
REQ-010 SHALL have: OUT_READY  in  1  register file accepts beat.
REQ-011 SHALL have: WB_DATA  out  32; WB_DEST  out  4; WB_FLAGS  out  4 {N,Z,C,O} of the beat.
REQ-012 SHALL have: STATUS  out  4  architectural flags {N,Z,C,O}.
REQ-013 SHALL have: COND  in  3; COND_TRUE  out  1  condition evaluated on STATUS.
REQ-014 SHALL have: CLR_SOV  in  1; SOV  out  1  sticky overflow.

Function
REQ-015 Input handshake SHALL complete on a cycle with IN_VALID=1 and IN_READY=1; output on OUT_VALID=1 and OUT_READY=1.
REQ-016 Storage SHALL be a 2-entry skid buffer: output register plus one skid register; beats leave in acceptance order.
REQ-017 An accepted beat SHALL appear on WB_* with OUT_VALID=1 the next cycle when the output register is empty or draining that cycle (latency 1).
REQ-018 If the output register is full and not draining, the accepted beat SHALL go to the skid register; IN_READY SHALL drop to 0 the next cycle.
REQ-019 IN_READY SHALL be 1 whenever the skid register is empty; when output drains, skid content SHALL move to output register next cycle and IN_READY return to 1.
REQ-020 Simultaneous accept and drain with one entry held SHALL keep occupancy at 1 with the new beat in the output register; no beat lost or duplicated.
REQ-021 WB_DATA/WB_DEST/WB_FLAGS SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 STATUS SHALL update at input acceptance when FLAG_WE=1 to {NF,ZF,CF,OF}; unchanged otherwise or without acceptance.
REQ-023 COND_TRUE SHALL be combinational on current STATUS: 000 always 1; 001 Z; 010 !Z; 011 C; 100 !C; 101 N; 110 O; 111 N^O.
REQ-024 Beats with IN_VALID=1 while IN_READY=0 SHALL be ignored without state change.

Reset
REQ-025 With Reset=1 at a rising edge: OUT_VALID=0, skid empty, IN_READY=1, WB_DATA=0, WB_DEST=0, WB_FLAGS=0, STATUS=0, SOV=0.
REQ-026 Reset SHALL dominate any simultaneous handshake; in-flight beats SHALL be discarded; inputs ignored while Reset=1.

Configuration
REQ-027 Macro STICKY_OVF_EN defined: SOV SHALL set on acceptance of a beat with FLAG_WE=1 and OF=1, clear on CLR_SOV=1; set wins when both occur same cycle.
REQ-028 Macro STICKY_OVF_EN undefined: SOV SHALL be constant 0, CLR_SOV ignored, no sticky flop inferred.

Verification
REQ-029 Single beat: Result=0x0000_0005, DEST=3, FLAG_WE=1, flags 0, OUT_READY=1 -> next cycle OUT_VALID=1, WB_DATA=5, WB_DEST=3, STATUS=0000.
REQ-030 Backpressure: OUT_READY=0, send beats 0xA then 0xB -> IN_READY=0 after second; raise OUT_READY -> WB_DATA 0xA then 0xB on consecutive cycles, IN_READY back to 1.
REQ-031 Flags/cond: accept beat ZF=1,NF=0,FLAG_WE=1 -> STATUS=0100, COND=001 gives 1, COND=010 gives 0; then beat FLAG_WE=0 ZF=0 -> STATUS unchanged.
REQ-032 Signed LT: accept NF=1, OF=0 -> COND=111 gives 1; accept NF=1, OF=1 -> 0.
REQ-033 Reset mid-stream: both entries full, assert Reset one cycle -> OUT_VALID=0, IN_READY=1, STATUS=0; no stale beat emerges.
REQ-034 With STICKY_OVF_EN: accept OF=1 FLAG_WE=1 -> SOV=1; subsequent OF=0 beats keep SOV=1; CLR_SOV pulse -> SOV=0; without macro SOV stays 0 throughout.
